// File: rtl/sysid_check_ctrl.sv
// Avalon-MM sequencer that reads system ID words 0 and 1 and checks them against build-time values.
// Optional macro SYSID_CHECK_AUTOSTART_EN: every reset release launches a check run.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5E5A_1B1E,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail_id,
    output logic        fail_ts,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_LAT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS  = 3'd3;
    localparam logic [2:0] S_LAT_TS = 3'd4;
    localparam logic [2:0] S_CMP    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);

    logic [2:0]  r_state;
    logic        r_address;
    logic        r_read;
    logic [31:0] r_id;
    logic [31:0] r_ts;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_fail_id;
    logic        r_fail_ts;
    logic        r_timeout;
    logic [15:0] r_wait_cnt;
    logic [1:0]  r_lat_cnt;

    logic w_start;
    logic w_in_rd;
    logic w_in_lat;
    logic w_capture;
    logic w_timeout;

`ifdef SYSID_CHECK_AUTOSTART_EN
    // Set throughout reset so the first released edge acts as a start pulse.
    logic r_auto_pend;
    always_ff @(posedge clock) begin
        if (reset) r_auto_pend <= 1'b1;
        else       r_auto_pend <= 1'b0;
    end
    assign w_start = start | r_auto_pend;
`else
    assign w_start = start;
`endif

    assign w_in_rd   = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_in_lat  = (r_state == S_LAT_ID) || (r_state == S_LAT_TS);
    // Data is taken on the accepting edge itself when the slave is combinational.
    assign w_capture = (READ_LATENCY == 0) ? (w_in_rd && !avm_waitrequest)
                                           : (w_in_lat && (r_lat_cnt == LAT_LAST));
    assign w_timeout = w_in_rd && avm_waitrequest && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_address  <= 1'b0;
            r_read     <= 1'b0;
            r_id       <= 32'd0;
            r_ts       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_id  <= 1'b0;
            r_fail_ts  <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= 16'd0;
            r_lat_cnt  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_fail_id  <= 1'b0;
                        r_fail_ts  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_read     <= 1'b1;
                        r_address  <= 1'b0;
                        r_wait_cnt <= 16'd0;
                        r_state    <= S_RD_ID;
                    end
                end
                S_RD_ID, S_RD_TS: begin
                    if (w_timeout) begin
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (avm_waitrequest) begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end else if (READ_LATENCY != 0) begin
                        r_read    <= 1'b0;
                        r_lat_cnt <= 2'd0;
                        r_state   <= r_address ? S_LAT_TS : S_LAT_ID;
                    end
                end
                S_LAT_ID, S_LAT_TS: begin
                    if (!w_capture) r_lat_cnt <= r_lat_cnt + 2'd1;
                end
                S_CMP: begin
                    r_fail_id <= (r_id != EXPECTED_ID);
                    r_fail_ts <= (r_ts != EXPECTED_TS);
                    r_pass    <= (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TS);
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Finishing the ID word chains straight into the timestamp read.
            if (w_capture) begin
                if (!r_address) begin
                    r_id       <= avm_readdata;
                    r_address  <= 1'b1;
                    r_read     <= 1'b1;
                    r_wait_cnt <= 16'd0;
                    r_state    <= S_RD_TS;
                end else begin
                    r_ts    <= avm_readdata;
                    r_read  <= 1'b0;
                    r_state <= S_CMP;
                end
            end
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign id_value    = r_id;
    assign ts_value    = r_ts;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_id     = r_fail_id;
    assign fail_ts     = r_fail_ts;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (latency 0 and 2) against a behavioural slave and run model.
module tb_sysid_check_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic start;
    always #5 clock = ~clock;

    logic [1:0]       avm_address, avm_read, waitreq;
    logic [1:0][31:0] readdata, id_v, ts_v;
    logic [1:0]       busy, done, pass, fail_id, fail_ts, tmo;

    sysid_check_ctrl #(.TIMEOUT_CYCLES(8)) u0 (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(waitreq[0]), .avm_readdata(readdata[0]),
        .id_value(id_v[0]), .ts_value(ts_v[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_id(fail_id[0]), .fail_ts(fail_ts[0]), .timeout(tmo[0])
    );

    sysid_check_ctrl #(.EXPECTED_ID(32'h1234_5678), .EXPECTED_TS(32'hCAFE_F00D),
                       .READ_LATENCY(2), .TIMEOUT_CYCLES(8)) u1 (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(waitreq[1]), .avm_readdata(readdata[1]),
        .id_value(id_v[1]), .ts_value(ts_v[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_id(fail_id[1]), .fail_ts(fail_ts[1]), .timeout(tmo[1])
    );

    // Instance properties as the bench sees them
    logic [31:0] exp_id [2] = '{32'h0000_0000, 32'h1234_5678};
    logic [31:0] exp_ts [2] = '{32'h5E5A_1B1E, 32'hCAFE_F00D};
    int          lat    [2] = '{0, 2};

    // Slave model: word store, per-read stall counts, fixed read latency
    logic [31:0] mem      [2][2];
    int          wait_cfg [2][2];
    bit          hold;
    int          wcnt [2];
    bit          pv1, pv2;
    logic        pa1, pa2;

    always_comb begin
        waitreq = '0;
        for (int i = 0; i < 2; i++)
            waitreq[i] = hold | (avm_read[i] && (wcnt[i] < wait_cfg[i][avm_address[i]]));
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++)
            wcnt[i] <= (avm_read[i] && waitreq[i]) ? wcnt[i] + 1 : 0;
        pv1 <= avm_read[1] && !waitreq[1];
        pa1 <= avm_address[1];
        pv2 <= pv1;
        pa2 <= pa1;
    end

    assign readdata[0] = (avm_read[0] && !waitreq[0]) ? mem[0][avm_address[0]] : 32'hDEAD_BEEF;
    assign readdata[1] = pv2 ? mem[1][pa2] : 32'hDEAD_BEEF;

    int n_tests = 0;
    int n_fail  = 0;
    int done_at [2];
    int rd_cnt  [2][2];
    bit busy0   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has just raised start or dropped reset; the next posedge is cycle 0.
    task automatic watch(input int max_k, input bit extra_start);
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            done_at[i] = -1;
            rd_cnt[i][0] = 0;
            rd_cnt[i][1] = 0;
            busy0[i] = busy[i];
        end
        for (int k = 0; k <= max_k; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i] && done_at[i] < 0) done_at[i] = k;
                if (avm_read[i]) rd_cnt[i][avm_address[i]]++;
            end
            if (extra_start && k == 0) start = 1'b1;
            if (k == 1) start = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic start_run(input bit extra_start);
        @(negedge clock);
        start = 1'b1;
        watch(40, extra_start);
    endtask

    // Expected outcome derived from the stored words, stall counts and latency
    task automatic check_run(input string tag, input bit exp_tmo);
        for (int i = 0; i < 2; i++) begin
            int  e_done, e_rd0, e_rd1;
            bit  e_fid, e_fts, e_pass;
            if (exp_tmo) begin
                e_done = 8; e_rd0 = 8; e_rd1 = 0;
                e_fid = 0; e_fts = 0; e_pass = 0;
            end else begin
                e_done = 3 + 2 * lat[i] + wait_cfg[i][0] + wait_cfg[i][1];
                e_rd0  = wait_cfg[i][0] + 1;
                e_rd1  = wait_cfg[i][1] + 1;
                e_fid  = (mem[i][0] != exp_id[i]);
                e_fts  = (mem[i][1] != exp_ts[i]);
                e_pass = !e_fid && !e_fts;
                chk($sformatf("%s_u%0d_id", tag, i), id_v[i], mem[i][0]);
                chk($sformatf("%s_u%0d_ts", tag, i), ts_v[i], mem[i][1]);
            end
            $display("[TB] run %s u%0d done_at=%0d rd0=%0d rd1=%0d pass=%0b fid=%0b fts=%0b tmo=%0b",
                     tag, i, done_at[i], rd_cnt[i][0], rd_cnt[i][1], pass[i], fail_id[i], fail_ts[i], tmo[i]);
            chk($sformatf("%s_u%0d_busy_c0", tag, i), 32'(busy0[i]), 32'd1);
            chk($sformatf("%s_u%0d_done_at", tag, i), done_at[i], e_done);
            chk($sformatf("%s_u%0d_rd_addr0", tag, i), rd_cnt[i][0], e_rd0);
            chk($sformatf("%s_u%0d_rd_addr1", tag, i), rd_cnt[i][1], e_rd1);
            chk($sformatf("%s_u%0d_verdict", tag, i),
                {28'd0, pass[i], fail_id[i], fail_ts[i], tmo[i]},
                {28'd0, e_pass, e_fid, e_fts, exp_tmo});
            chk($sformatf("%s_u%0d_idle", tag, i),
                {29'd0, done[i], busy[i], avm_read[i]}, {29'd0, 3'b100});
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_u%0d_flags", tag, i),
                {24'd0, avm_address[i], avm_read[i], busy[i], done[i], pass[i],
                 fail_id[i], fail_ts[i], tmo[i]}, 32'd0);
            chk($sformatf("%s_u%0d_idv", tag, i), id_v[i], 32'd0);
            chk($sformatf("%s_u%0d_tsv", tag, i), ts_v[i], 32'd0);
        end
    endtask

    task automatic check_no_run(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_u%0d_no_done", tag, i), done_at[i], -1);
            chk($sformatf("%s_u%0d_no_read", tag, i), rd_cnt[i][0] + rd_cnt[i][1], 0);
            chk($sformatf("%s_u%0d_not_busy", tag, i), 32'(busy[i]), 32'd0);
        end
    endtask

    task automatic set_match();
        for (int i = 0; i < 2; i++) begin
            mem[i][0] = exp_id[i];
            mem[i][1] = exp_ts[i];
            wait_cfg[i][0] = 0;
            wait_cfg[i][1] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        set_match();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");

        // Reset release: autostart runs a check, otherwise the block stays idle
        wait_cfg[1][0] = 4;
        @(negedge clock);
        reset = 1'b0;
`ifdef SYSID_CHECK_AUTOSTART_EN
        watch(30, 1'b0);
        check_run("autostart", 1'b0);
`else
        watch(100, 1'b0);
        check_no_run("no_autostart");
`endif

        // Matching words, 4 stalls on the latency-2 ID read, redundant start at cycle 1
        set_match();
        wait_cfg[1][0] = 4;
        start_run(1'b1);
        check_run("start_ignored", 1'b0);

        // Timestamp off by one on u0, ID wrong on u1
        mem[0][1] = 32'h5E5A_1B1F;
        mem[1][0] = 32'h1234_5679;
        start_run(1'b0);
        check_run("mismatch", 1'b0);

        // One stall short of the timeout limit must still complete
        set_match();
        wait_cfg[0][0] = 7;
        wait_cfg[1][1] = 7;
        start_run(1'b0);
        check_run("wait7", 1'b0);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 2; i++) begin
                mem[i][0] = ($urandom_range(0, 1) == 1) ? exp_id[i] : $urandom;
                mem[i][1] = ($urandom_range(0, 1) == 1) ? exp_ts[i] : $urandom;
                wait_cfg[i][0] = $urandom_range(0, 5);
                wait_cfg[i][1] = $urandom_range(0, 5);
            end
            start_run(1'b0);
            check_run($sformatf("rand%0d", r), 1'b0);
        end

        // Slave stalls forever
        set_match();
        hold = 1'b1;
        start_run(1'b0);
        check_run("timeout", 1'b1);
        hold = 1'b0;

        // Start again at cycle 1, then reset at cycle 2 aborts the run
        set_match();
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        check_all_zero("abort");
        @(negedge clock); reset = 1'b0;
        watch(30, 1'b0);
`ifdef SYSID_CHECK_AUTOSTART_EN
        check_run("restart", 1'b0);
`else
        check_no_run("after_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
